memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Memory stage: passes ALU results straight to writeback and runs load/store accesses through an IDLE/ACCESS handshake.
// Build option MEM_SUBWORD_EN enables byte/halfword accesses; without it every access is a full aligned word.
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ValidIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        MemToRegIn,
  input  logic        BranchIn,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] StoreDataIn,
  input  logic [4:0]  RdIn,
  input  logic [2:0]  Funct3In,
  output logic        DmemReq,
  output logic        DmemWe,
  output logic [31:0] DmemAddr,
  output logic [31:0] DmemWData,
  output logic [3:0]  DmemByteEn,
  input  logic        DmemAck,
  input  logic [31:0] DmemRData,
  output logic        ValidOut,
  output logic        MemToRegOut,
  output logic        BranchOut,
  output logic [31:0] ALUResultOut,
  output logic [31:0] MemDataOut,
  output logic [4:0]  RdOut,
  output logic        StallOut
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic        lat_we;
  logic        lat_m2r;
  logic        lat_br;
  logic [31:0] lat_alu;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic [4:0]  lat_rd;

  logic        mem_op;
  logic [31:0] addr_fmt;
  logic [31:0] wdata_fmt;
  logic [3:0]  be_fmt;
  logic [31:0] load_data;

  assign mem_op = ValidIn && (MemReadIn || MemWriteIn);

`ifdef MEM_SUBWORD_EN
  logic [2:0] lat_f3;
  logic       is_byte;
  logic       is_half;
  logic [7:0] load_byte;
  logic [15:0] load_half;

  // Codes 100/101 only mean byte/half for loads; for stores they fall back to word.
  always_comb begin
    is_byte   = (Funct3In == 3'b000) || (!MemWriteIn && (Funct3In == 3'b100));
    is_half   = (Funct3In == 3'b001) || (!MemWriteIn && (Funct3In == 3'b101));
    addr_fmt  = {ALUResultIn[31:2], 2'b00};
    wdata_fmt = StoreDataIn;
    be_fmt    = 4'b1111;
    if (is_byte) begin
      addr_fmt = ALUResultIn;
      if (MemWriteIn) begin
        wdata_fmt = {4{StoreDataIn[7:0]}};
        be_fmt    = 4'b0001 << ALUResultIn[1:0];
      end
    end else if (is_half) begin
      addr_fmt = ALUResultIn;
      if (MemWriteIn) begin
        wdata_fmt = {2{StoreDataIn[15:0]}};
        be_fmt    = ALUResultIn[1] ? 4'b1100 : 4'b0011;
      end
    end
  end

  always_comb begin
    case (lat_addr[1:0])
      2'b01:   load_byte = DmemRData[15:8];
      2'b10:   load_byte = DmemRData[23:16];
      2'b11:   load_byte = DmemRData[31:24];
      default: load_byte = DmemRData[7:0];
    endcase
    load_half = lat_addr[1] ? DmemRData[31:16] : DmemRData[15:0];
    case (lat_f3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'd0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'd0, load_half};
      default: load_data = DmemRData;
    endcase
  end
`else
  logic unused_f3;

  assign unused_f3 = ^Funct3In;
  assign addr_fmt  = {ALUResultIn[31:2], 2'b00};
  assign wdata_fmt = StoreDataIn;
  assign be_fmt    = 4'b1111;
  assign load_data = DmemRData;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_we       <= 1'b0;
      lat_m2r      <= 1'b0;
      lat_br       <= 1'b0;
      lat_alu      <= 32'd0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      lat_be       <= 4'd0;
      lat_rd       <= 5'd0;
      ValidOut     <= 1'b0;
      MemToRegOut  <= 1'b0;
      BranchOut    <= 1'b0;
      ALUResultOut <= 32'd0;
      MemDataOut   <= 32'd0;
      RdOut        <= 5'd0;
`ifdef MEM_SUBWORD_EN
      lat_f3       <= 3'd0;
`endif
    end else begin
      // Writeback sees a clean bubble unless a result is registered this cycle.
      ValidOut     <= 1'b0;
      MemToRegOut  <= 1'b0;
      BranchOut    <= 1'b0;
      ALUResultOut <= 32'd0;
      MemDataOut   <= 32'd0;
      RdOut        <= 5'd0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            lat_we    <= MemWriteIn;
            lat_m2r   <= MemToRegIn;
            lat_br    <= BranchIn;
            lat_alu   <= ALUResultIn;
            lat_addr  <= addr_fmt;
            lat_wdata <= wdata_fmt;
            lat_be    <= be_fmt;
            lat_rd    <= RdIn;
`ifdef MEM_SUBWORD_EN
            lat_f3    <= Funct3In;
`endif
            state     <= ACCESS;
          end else if (ValidIn) begin
            ValidOut     <= 1'b1;
            MemToRegOut  <= MemToRegIn;
            BranchOut    <= BranchIn;
            ALUResultOut <= ALUResultIn;
            RdOut        <= RdIn;
          end
        end
        ACCESS: begin
          if (DmemAck) begin
            ValidOut     <= 1'b1;
            MemToRegOut  <= lat_m2r;
            BranchOut    <= lat_br;
            ALUResultOut <= lat_alu;
            MemDataOut   <= lat_we ? 32'd0 : load_data;
            RdOut        <= lat_we ? 5'd0 : lat_rd;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign DmemReq    = (state == ACCESS);
  assign DmemWe     = (state == ACCESS) && lat_we;
  assign DmemAddr   = lat_addr;
  assign DmemWData  = lat_wdata;
  assign DmemByteEn = lat_be;
  assign StallOut   = (state == IDLE) ? mem_op : !DmemAck;

endmodule
